// File: rtl/fwd_scoreboard_if.sv
// Decode-side bundle for fwd_scoreboard.
// The decoder (master) presents the ID-stage instruction, already collapsed to
// sources / destination / write-enable / load flag, plus the pipeline flush.
// The scoreboard (slave) answers with per-operand forward selects, the
// load-use stall and the saturating stall counter.
//   id_valid     decode slot holds a real instruction
//   id_src       NUM_SRC packed source register numbers
//   id_src_used  per-operand "actually read" flags
//   id_dst       resolved destination register
//   id_dst_we    instruction writes id_dst
//   id_is_load   result comes from memory
//   flush        kill in-flight entries and the decode instruction
//   fwd_sel      per operand: 0 = register file, k = forward from stage k
//   stall        hold PC/IF/ID, bubble into EX
//   stall_count  saturating count of stall cycles
interface fwd_scoreboard_if #(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int SELW    = 2,
  parameter int CNT_W   = 16
);
  logic                      id_valid;
  logic [NUM_SRC*REG_AW-1:0] id_src;
  logic [NUM_SRC-1:0]        id_src_used;
  logic [REG_AW-1:0]         id_dst;
  logic                      id_dst_we;
  logic                      id_is_load;
  logic                      flush;
  logic [NUM_SRC*SELW-1:0]   fwd_sel;
  logic                      stall;
  logic [CNT_W-1:0]          stall_count;

  modport master (
    output id_valid, id_src, id_src_used, id_dst, id_dst_we, id_is_load, flush,
    input  fwd_sel, stall, stall_count
  );

  modport slave (
    input  id_valid, id_src, id_src_used, id_dst, id_dst_we, id_is_load, flush,
    output fwd_sel, stall, stall_count
  );
endinterface

// File: rtl/fwd_scoreboard.sv
// Forwarding scoreboard beside the ID stage.
// Tracks the destination of each instruction in the DEPTH stages after decode
// (stage 1 = EX ... stage DEPTH), and for every decode source operand picks the
// youngest in-flight producer. A producer that is too young to have its result
// (loads before LOAD_READY, ALU ops before ALU_READY) raises a stall, which
// suppresses insertion of the decode instruction so a bubble enters stage 1.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset, priority over everything
//   sb   fwd_scoreboard_if.slave (decode inputs, forward/stall outputs)
module fwd_scoreboard #(
  parameter int REG_AW     = 5,
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 3,
  parameter int ALU_READY  = 1,
  parameter int LOAD_READY = 2,
  parameter int SELW       = $clog2(DEPTH + 1),
  parameter int CNT_W      = 16
) (
  input  logic           clk,
  input  logic           rst,
  fwd_scoreboard_if.slave sb
);

  logic [DEPTH:1]    v_q;
  logic [DEPTH:1]    ld_q;
  logic [REG_AW-1:0] dst_q [1:DEPTH];
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [NUM_SRC*SELW-1:0] sel_raw;
  logic [NUM_SRC-1:0]      not_ready;
  logic                    stall;
  logic                    v1_d;

  // Scan oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    sel_raw   = '0;
    not_ready = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = DEPTH; k >= 1; k--) begin
        if (v_q[k] && sb.id_src_used[i] &&
            (dst_q[k] == sb.id_src[i*REG_AW +: REG_AW]) &&
            (sb.id_src[i*REG_AW +: REG_AW] != '0)) begin
          sel_raw[i*SELW +: SELW] = SELW'(k);
          not_ready[i]            = ld_q[k] ? (k < LOAD_READY) : (k < ALU_READY);
        end
      end
    end
  end

  assign stall = sb.id_valid & ~sb.flush & (|not_ready);
  assign v1_d  = sb.id_valid & sb.id_dst_we & (sb.id_dst != '0) & ~stall;
  assign cnt_d = (stall && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;

  assign sb.fwd_sel     = stall ? '0 : sel_raw;
  assign sb.stall       = stall;
  assign sb.stall_count = cnt_q;

  // Payload fields only matter while the matching valid bit is set, so they
  // shift freely and carry no reset.
  always_ff @(posedge clk) begin
    for (int k = DEPTH; k >= 2; k--) begin
      dst_q[k] <= dst_q[k-1];
      ld_q[k]  <= ld_q[k-1];
    end
    dst_q[1] <= sb.id_dst;
    ld_q[1]  <= sb.id_is_load;

    if (rst) begin
      v_q   <= '0;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (sb.flush) begin
        v_q <= '0;
      end else begin
        for (int k = DEPTH; k >= 2; k--) v_q[k] <= v_q[k-1];
        v_q[1] <= v1_d;
      end
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
module tb_fwd_scoreboard;
  localparam int REG_AW = 5;
  localparam int NSRC   = 2;
  localparam int DEPTH  = 3;
  localparam int ALU_R  = 1;
  localparam int LOAD_R = 2;
  localparam int SELW   = 2;
  localparam int CNT_W  = 4;
  localparam int CMAX   = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fwd_scoreboard_if #(.REG_AW(REG_AW), .NUM_SRC(NSRC), .SELW(SELW), .CNT_W(CNT_W)) sb ();

  fwd_scoreboard #(
    .REG_AW(REG_AW), .NUM_SRC(NSRC), .DEPTH(DEPTH), .ALU_READY(ALU_R),
    .LOAD_READY(LOAD_R), .SELW(SELW), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sb (sb)
  );

  // Reference model: a queue of in-flight instructions, index 0 = stage 1.
  typedef struct {
    bit v;
    int dst;
    bit ld;
  } ent_t;

  ent_t pipe[$];
  int   m_cnt;
  bit   exp_stall;
  int   exp_sel [NSRC];

  int total = 0;
  int bad   = 0;

  // current stimulus, kept for the model update at the clock edge
  bit c_rst, c_valid, c_we, c_ld, c_fl;
  int c_src [NSRC];
  bit [NSRC-1:0] c_used;
  int c_dst;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < DEPTH; k++) pipe[k].v = 1'b0;
  endtask

  // Apply inputs, then at the falling edge predict and compare outputs.
  task automatic drive(input bit r, input bit valid, input int s0, input int s1,
                       input bit [1:0] used, input int dst, input bit we,
                       input bit ld, input bit fl);
    bit any_nr;
    c_rst = r; c_valid = valid; c_src[0] = s0; c_src[1] = s1; c_used = used;
    c_dst = dst; c_we = we; c_ld = ld; c_fl = fl;
    rst            = r;
    sb.id_valid    = valid;
    sb.id_src      = {REG_AW'(s1), REG_AW'(s0)};
    sb.id_src_used = used;
    sb.id_dst      = REG_AW'(dst);
    sb.id_dst_we   = we;
    sb.id_is_load  = ld;
    sb.flush       = fl;
    @(negedge clk);

    any_nr = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      exp_sel[i] = 0;
      if (c_used[i] && c_src[i] != 0) begin
        foreach (pipe[k]) begin
          if (exp_sel[i] == 0 && pipe[k].v && pipe[k].dst == c_src[i]) begin
            exp_sel[i] = k + 1;
            if ((k + 1) < (pipe[k].ld ? LOAD_R : ALU_R)) any_nr = 1'b1;
          end
        end
      end
    end
    exp_stall = c_valid && !c_fl && any_nr;
    if (exp_stall) begin
      exp_sel[0] = 0;
      exp_sel[1] = 0;
    end
    chk("stall", 32'(sb.stall), 32'(exp_stall));
    chk("sel0", 32'(sb.fwd_sel[SELW-1:0]), 32'(exp_sel[0]));
    chk("sel1", 32'(sb.fwd_sel[2*SELW-1:SELW]), 32'(exp_sel[1]));
    chk("count", 32'(sb.stall_count), 32'(m_cnt));
  endtask

  task automatic adv();
    ent_t e;
    @(posedge clk);
    if (c_rst) begin
      model_clear();
      m_cnt = 0;
    end else begin
      if (exp_stall && m_cnt < CMAX) m_cnt++;
      if (c_fl) begin
        model_clear();
      end else begin
        e.v   = c_valid && c_we && c_dst != 0 && !exp_stall;
        e.dst = c_dst;
        e.ld  = c_ld;
        pipe.push_front(e);
        void'(pipe.pop_back());
      end
    end
    #1;
  endtask

  task automatic step(input bit r, input bit valid, input int s0, input int s1,
                      input bit [1:0] used, input int dst, input bit we,
                      input bit ld, input bit fl);
    drive(r, valid, s0, s1, used, dst, we, ld, fl);
    adv();
  endtask

  initial begin
    ent_t z;
    z.v = 1'b0; z.dst = 0; z.ld = 1'b0;
    for (int k = 0; k < DEPTH; k++) pipe.push_back(z);
    m_cnt = 0;

    // reset
    step(1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    step(1, 1, 1, 2, 2'b11, 1, 1, 0, 0);
    drive(0, 1, 1, 2, 2'b11, 0, 0, 0, 0);
    chk("rst_stall", 32'(sb.stall), 0);
    chk("rst_count", 32'(sb.stall_count), 0);
    adv();

    // ALU back-to-back
    step(0, 1, 0, 0, 2'b00, 3, 1, 0, 0);
    drive(0, 1, 3, 0, 2'b01, 0, 0, 0, 0);
    chk("alu_s1", 32'(sb.fwd_sel[SELW-1:0]), 1);
    adv();
    drive(0, 1, 3, 0, 2'b01, 0, 0, 0, 0);
    chk("alu_s2", 32'(sb.fwd_sel[SELW-1:0]), 2);
    adv();

    // load-use
    step(0, 1, 0, 0, 2'b00, 5, 1, 1, 0);
    drive(0, 1, 0, 5, 2'b10, 8, 1, 0, 0);
    chk("lu_stall", 32'(sb.stall), 1);
    adv();
    drive(0, 1, 0, 5, 2'b10, 8, 1, 0, 0);
    chk("lu_sel", 32'(sb.fwd_sel[2*SELW-1:SELW]), 2);
    chk("lu_cnt", 32'(sb.stall_count), 1);
    adv();

    // youngest priority, register 0
    step(0, 1, 0, 0, 2'b00, 7, 1, 0, 0);
    step(0, 1, 0, 0, 2'b00, 9, 1, 0, 0);
    step(0, 1, 0, 0, 2'b00, 7, 1, 0, 0);
    drive(0, 1, 7, 9, 2'b11, 0, 1, 0, 0);
    chk("young", 32'(sb.fwd_sel[SELW-1:0]), 1);
    adv();
    step(0, 1, 0, 0, 2'b00, 0, 1, 0, 0);
    step(0, 1, 0, 0, 2'b00, 0, 1, 1, 0);
    drive(0, 1, 0, 0, 2'b11, 0, 1, 0, 0);
    chk("zero", 32'(sb.fwd_sel), 0);
    adv();

    // flush during would-be stall
    step(0, 1, 0, 0, 2'b00, 4, 1, 1, 0);
    drive(0, 1, 4, 4, 2'b11, 6, 1, 0, 1);
    chk("fl_stall", 32'(sb.stall), 0);
    adv();
    drive(0, 1, 4, 4, 2'b11, 0, 0, 0, 0);
    chk("fl_sel", 32'(sb.fwd_sel), 0);
    adv();

    // counter saturation: keep reloading a dependent load
    step(0, 1, 0, 0, 2'b00, 6, 1, 1, 0);
    for (int n = 0; n < 40; n++) step(0, 1, 6, 0, 2'b01, 6, 1, 1, 0);
    drive(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    chk("sat", 32'(sb.stall_count), CMAX);
    adv();

    // reset mid-stream
    step(0, 1, 0, 0, 2'b00, 10, 1, 0, 0);
    step(0, 1, 0, 0, 2'b00, 11, 1, 1, 0);
    step(0, 1, 0, 0, 2'b00, 12, 1, 1, 0);
    step(1, 1, 12, 11, 2'b11, 13, 1, 0, 0);
    drive(0, 1, 12, 11, 2'b11, 0, 0, 0, 0);
    chk("mrst_sel", 32'(sb.fwd_sel), 0);
    chk("mrst_stall", 32'(sb.stall), 0);
    chk("mrst_cnt", 32'(sb.stall_count), 0);
    adv();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0),
           int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           2'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 24) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised successor to the per-operand forwarding units: one block tracks in-flight destination registers for DEPTH pipeline stages after decode.
- Per decode-stage source operand, it produces an encoded forward-select; it also produces a load-use stall and keeps a saturating stall counter.
- Sits beside the ID stage, replacing the per-stage/per-operand combinational forward units.
- Owns its own destination shift register, so instruction decode flags (isW_*, isR_*) are collapsed by the decoder into dst/we/is_load before entry.

Parameters:
- REG_AW, 5, register-address width; register 0 is hardwired zero.
- NUM_SRC, 2, source operands checked per decode instruction (rs, rt).
- DEPTH, 3, tracked stages after ID (stage 1=EX, 2=MEM, 3=WB).
- ALU_READY, 1, first stage index from which a non-load result is forwardable.
- LOAD_READY, 2, first stage index from which a load result is forwardable.
- SELW, clog2(DEPTH+1), forward-select width.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  decode slot holds a real instruction.
- id_src  in  NUM_SRC*REG_AW  source register numbers; operand i is at bits [i*REG_AW +: REG_AW].
- id_src_used  in  NUM_SRC  operand i is actually read.
- id_dst  in  REG_AW  destination register (rd, rt or 31, already resolved by the decoder).
- id_dst_we  in  1  instruction writes id_dst.
- id_is_load  in  1  result comes from memory.
- flush  in  1  kill all in-flight entries and the decode instruction.
- fwd_sel  out  NUM_SRC*SELW  per operand: 0 = register file; k = forward from stage k.
- stall  out  1  hold PC/IF/ID, insert a bubble into EX.
- stall_count  out  CNT_W  saturating count of stall cycles.

Behaviour:
- State:
  - DEPTH entries, each {v, dst, ld}. Entry k corresponds to stage k.
  - stall_count register.
- Reset:
  - All v=0; stall_count=0.
  - Consequently fwd_sel=0 and stall=0 in the cycle after reset deasserts, until entries fill.
  - Reset has priority over flush and all other inputs. Reset mid-operation drops every entry.
- Match rule for operand i at stage k:
  - Requires v[k], dst[k]==src_i, src_i!=0, and id_src_used[i].
  - The youngest match (lowest k) wins; older matches are ignored.
- Ready rule:
  - A match is ready if k>=LOAD_READY when ld[k]=1.
  - A match is ready if k>=ALU_READY when ld[k]=0.
- stall (combinational) = id_valid & !flush & (some operand's winning match is not ready).
- fwd_sel_i (combinational):
  - Equals the winning k when a match exists and stall=0.
  - Equals 0 when there is no match, or when stall=1.
- Shift each clock (when not rst):
  - flush=1: all v<=0 (the decode instruction is not inserted).
  - Otherwise, entries k+1 <= k for k=1..DEPTH-1, and entry DEPTH is discarded.
  - Entry 1 <= {id_valid & id_dst_we & (id_dst!=0) & !stall, id_dst, id_is_load}. A stall therefore inserts a bubble.
  - An instruction with id_dst_we=0 or id_dst=0 enters as v=0.
- stall_count increments by 1 on each clock with stall=1, and saturates at 2^CNT_W-1 (no wrap).
- Simultaneous events:
  - flush and a would-be stall: stall is forced to 0, and the counter does not increment.
  - Both operands match different stages: selects are independent per operand.
  - Both operands equal the same register: both get the same select.
- Latency:
  - fwd_sel and stall are zero-cycle, combinational from current state and inputs.
  - Entries advance one stage per clock regardless of stall; only the ID insert is suppressed.
- Stage-DEPTH matches forward normally, even though the register file is written in the same cycle.

Test Plan:
- ALU back-to-back: add r3 enters (dst=3, ld=0), next cycle id_src0=3 → fwd_sel0=1, stall=0; the following cycle with r3 at stage 2 → fwd_sel0=2.
- Load-use:
  - lw r5 enters, next cycle id_src1=5 → stall=1 and fwd_sel1=0.
  - Next cycle (load at stage 2, bubble at stage 1) → stall=0, fwd_sel1=2; stall_count=1.
- Youngest priority: r7 written at stages 3 and 1 → fwd_sel=1. Register 0 at every stage with src=0 → fwd_sel=0.
- Flush during stall: load at stage 1 with dependent decode, flush=1 → stall=0, stall_count unchanged; next cycle all entries invalid, fwd_sel=0.
- Saturation: CNT_W=4, hold a stall condition for 20 cycles (keep reloading the load) → stall_count stops at 15.
- Reset mid-stream: three valid entries, rst=1 for one clock → next cycle all selects 0, stall=0, stall_count=0.
